// File: rtl/vga_sync_gen.sv
`timescale 1ns/1ps
// VGA timing generator: pixel-rate divider, horizontal/vertical counters,
// registered active-low syncs and a one-clk strobe at the start of vertical blanking.
module vga_sync_gen #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned CLK_DIV   = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       refresh_tick
);

    localparam int unsigned H_TOTAL      = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_START = H_DISPLAY + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int unsigned V_SYNC_START = V_DISPLAY + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;
    localparam int unsigned DIV_W        = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [9:0]       h_d;
    logic [9:0]       v_d;
    logic             tick_d;
    logic             tick_dly_q;
    logic             hsync_d;
    logic             vsync_d;
    logic             refresh_d;

    // Next-state: divider, counters, and syncs decoded from the next counter value
    always_comb begin
        div_d     = (div_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_q + DIV_W'(1);
        h_d       = pixel_x;
        v_d       = pixel_y;
        tick_d    = (div_q == DIV_W'(CLK_DIV - 2));
        hsync_d   = 1'b1;
        vsync_d   = 1'b1;
        refresh_d = 1'b0;

        if (p_tick) begin
            if (pixel_x == 10'(H_TOTAL - 1)) begin
                h_d = '0;
                if (pixel_y == 10'(V_TOTAL - 1)) begin
                    v_d = '0;
                end else begin
                    v_d = pixel_y + 10'd1;
                end
            end else begin
                h_d = pixel_x + 10'd1;
            end
        end

        if ((h_d >= 10'(H_SYNC_START)) && (h_d <= 10'(H_SYNC_END))) begin
            hsync_d = 1'b0;
        end
        if ((v_d >= 10'(V_SYNC_START)) && (v_d <= 10'(V_SYNC_END))) begin
            vsync_d = 1'b0;
        end

        // tick_dly_q marks the first cycle after a pixel edge, so this fires once
        refresh_d = tick_dly_q && (pixel_x == 10'd0) && (pixel_y == 10'(V_DISPLAY));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q        <= '0;
            p_tick       <= 1'b0;
            tick_dly_q   <= 1'b0;
            pixel_x      <= '0;
            pixel_y      <= '0;
            hsync        <= 1'b1;
            vsync        <= 1'b1;
            refresh_tick <= 1'b0;
        end else begin
            div_q        <= div_d;
            p_tick       <= tick_d;
            tick_dly_q   <= p_tick;
            pixel_x      <= h_d;
            pixel_y      <= v_d;
            hsync        <= hsync_d;
            vsync        <= vsync_d;
            refresh_tick <= refresh_d;
        end
    end

    assign video_on = (pixel_x < 10'(H_DISPLAY)) && (pixel_y < 10'(V_DISPLAY));

endmodule

// File: tb/tb_vga_sync_gen.sv
`timescale 1ns/1ps
// Scoreboard bench: a default-timing instance for line-level checks and a
// small-timing instance for frame wrap, vsync, refresh strobes and mid-frame reset.
module tb_vga_sync_gen;

    typedef struct {
        int n;
        int x;
        int y;
        int hs;
        int vs;
        int von;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       d_tick, d_von, d_hs, d_vs, d_rt;
    logic [9:0] d_x, d_y;
    logic       s_tick, s_von, s_hs, s_vs, s_rt;
    logic [9:0] s_x, s_y;

    int   errors = 0;
    int   checks = 0;
    int   c = 0;
    bit   rf_en = 1'b1;
    int   hs_low = 0;
    exp_t q_d[$];
    exp_t q_s[$];
    int   rq[$];
    int   tq[$];

    always #5 clk = ~clk;

    vga_sync_gen dut_d (
        .clk(clk), .reset(reset), .p_tick(d_tick), .pixel_x(d_x), .pixel_y(d_y),
        .video_on(d_von), .hsync(d_hs), .vsync(d_vs), .refresh_tick(d_rt)
    );

    // H_TOTAL=12 (sync 8..10), V_TOTAL=8 (sync 5..6), 3 clk per pixel
    vga_sync_gen #(
        .H_DISPLAY(6), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_DISPLAY(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(3)
    ) dut_s (
        .clk(clk), .reset(reset), .p_tick(s_tick), .pixel_x(s_x), .pixel_y(s_y),
        .video_on(s_von), .hsync(s_hs), .vsync(s_vs), .refresh_tick(s_rt)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int n, input int x, input int y,
                                input int hs, input int vs, input int von);
        exp_t e;
        e.n = n; e.x = x; e.y = y; e.hs = hs; e.vs = vs; e.von = von;
        return e;
    endfunction

    task automatic cmp_exp(input string tag, input exp_t e, input int x, input int y,
                           input int hs, input int vs, input int von);
        check($sformatf("%s_x@%0d", tag, e.n), x, e.x);
        check($sformatf("%s_y@%0d", tag, e.n), y, e.y);
        check($sformatf("%s_hsync@%0d", tag, e.n), hs, e.hs);
        check($sformatf("%s_vsync@%0d", tag, e.n), vs, e.vs);
        check($sformatf("%s_video_on@%0d", tag, e.n), von, e.von);
    endtask

    // clk edges since reset release
    always @(posedge clk) begin
        if (reset) c <= 0;
        else       c <= c + 1;
    end

    // Default-instance monitor: count pixel edges, compare when an expectation is due
    int cnt_d = 0;
    bit prev_d = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            cnt_d = 0;
            prev_d = 1'b0;
        end else begin
            if (prev_d) cnt_d++;
            prev_d = d_tick;
            while (q_d.size() > 0 && q_d[0].n == cnt_d) begin
                exp_t e;
                e = q_d.pop_front();
                cmp_exp("def", e, int'(d_x), int'(d_y), int'(d_hs), int'(d_vs), int'(d_von));
            end
        end
    end

    int cnt_s = 0;
    bit prev_s = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            cnt_s = 0;
            prev_s = 1'b0;
        end else begin
            if (prev_s) cnt_s++;
            prev_s = s_tick;
            while (q_s.size() > 0 && q_s[0].n == cnt_s) begin
                exp_t e;
                e = q_s.pop_front();
                cmp_exp("small", e, int'(s_x), int'(s_y), int'(s_hs), int'(s_vs), int'(s_von));
            end
        end
    end

    // p_tick observed high in cycle c is consumed by edge c+1
    always @(negedge clk) begin
        if (!reset && d_tick && tq.size() > 0) check("def_tick_edge", c + 1, tq.pop_front());
    end

    always @(negedge clk) begin
        if (!reset && rf_en && s_rt) begin
            if (rq.size() == 0) check("small_refresh_extra", c, -1);
            else                check("small_refresh_at", c, rq.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!reset && c < 3300 && d_hs == 1'b0) hs_low++;
    end

    initial begin
        int found;
        int bad;

        q_d.push_back(mk(0,    0,   0, 1, 1, 1));
        q_d.push_back(mk(1,    1,   0, 1, 1, 1));
        q_d.push_back(mk(639,  639, 0, 1, 1, 1));
        q_d.push_back(mk(640,  640, 0, 1, 1, 0));
        q_d.push_back(mk(655,  655, 0, 1, 1, 0));
        q_d.push_back(mk(656,  656, 0, 0, 1, 0));
        q_d.push_back(mk(751,  751, 0, 0, 1, 0));
        q_d.push_back(mk(752,  752, 0, 1, 1, 0));
        q_d.push_back(mk(799,  799, 0, 1, 1, 0));
        q_d.push_back(mk(800,  0,   1, 1, 1, 1));
        q_d.push_back(mk(4799, 799, 5, 1, 1, 0));
        q_d.push_back(mk(4800, 0,   6, 1, 1, 1));

        q_s.push_back(mk(0,   0,  0, 1, 1, 1));
        q_s.push_back(mk(5,   5,  0, 1, 1, 1));
        q_s.push_back(mk(6,   6,  0, 1, 1, 0));
        q_s.push_back(mk(8,   8,  0, 0, 1, 0));
        q_s.push_back(mk(10,  10, 0, 0, 1, 0));
        q_s.push_back(mk(11,  11, 0, 1, 1, 0));
        q_s.push_back(mk(12,  0,  1, 1, 1, 1));
        q_s.push_back(mk(47,  11, 3, 1, 1, 0));
        q_s.push_back(mk(48,  0,  4, 1, 1, 0));
        q_s.push_back(mk(60,  0,  5, 1, 0, 0));
        q_s.push_back(mk(68,  8,  5, 0, 0, 0));
        q_s.push_back(mk(83,  11, 6, 1, 0, 0));
        q_s.push_back(mk(84,  0,  7, 1, 1, 0));
        q_s.push_back(mk(95,  11, 7, 1, 1, 0));
        q_s.push_back(mk(96,  0,  0, 1, 1, 1));
        q_s.push_back(mk(191, 11, 7, 1, 1, 0));
        q_s.push_back(mk(192, 0,  0, 1, 1, 1));
        q_s.push_back(mk(288, 0,  0, 1, 1, 1));

        tq = '{4, 8, 12};
        // (0,4) reached at edge 48*3=144, strobe seen one clk later; frame = 288 clk
        rq = '{145, 433, 721};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        repeat (900) @(posedge clk);
        #1;
        check("small_refresh_missing", rq.size(), 0);
        rf_en = 1'b0;

        repeat (19300 - 900) @(posedge clk);
        #1;
        check("def_queue_left", q_d.size(), 0);
        check("small_queue_left", q_s.size(), 0);
        check("def_tick_left", tq.size(), 0);
        check("def_hsync_low_clks", hs_low, 384);

        // Reset while small instance is inside both sync windows
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            @(negedge clk);
            if (s_x == 10'd9 && s_y == 10'd5) found = 1;
        end
        check("small_found_sync_window", found, 1);
        check("small_hsync_pre", int'(s_hs), 0);
        check("small_vsync_pre", int'(s_vs), 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_small_x", int'(s_x), 0);
        check("rst_small_y", int'(s_y), 0);
        check("rst_small_hsync", int'(s_hs), 1);
        check("rst_small_vsync", int'(s_vs), 1);
        check("rst_small_tick", int'(s_tick), 0);
        check("rst_small_refresh", int'(s_rt), 0);
        check("rst_def_x", int'(d_x), 0);
        check("rst_def_tick", int'(d_tick), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_def_tick", int'(d_tick), 0);
        check("post_rst_small_tick", int'(s_tick), 0);

        // Reset during a refresh strobe
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            @(negedge clk);
            if (s_rt) found = 1;
        end
        check("small_found_refresh", found, 1);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst2_small_refresh", int'(s_rt), 0);
        check("rst2_small_y", int'(s_y), 0);
        check("rst2_small_tick", int'(s_tick), 0);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_rt || !s_vs) bad++;
        end
        check("small_quiet_after_reset", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
